// File: rtl/ula_arb2.sv
// Two-requester arbiter/sequencer sharing one ula32 ALU. One operation is in flight
// at a time: IDLE (arbitrate/capture) -> EXEC (run ALU) -> RESP (hold until consumed).

module ula32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  op,
   output logic [31:0] result,
   output logic [3:0]  flags
);
   logic [31:0] b_eff;
   logic [32:0] sum;
   logic        c;
   logic        v;

   always_comb begin
      b_eff  = op[0] ? ~b : b;
      sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, op[0]};
      result = sum[31:0];
      c      = sum[32];
      v      = ~(a[31] ^ b[31] ^ op[0]) & (a[31] ^ sum[31]);
      if (op[1]) begin
         result = op[0] ? (a | b) : (a & b);
         c      = 1'b0;
         v      = 1'b0;
      end
      flags = {result[31], (result == 32'd0), c, v};
   end
endmodule

module ula_arb2 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [1:0]  req_op0,
   input  logic        req_setf0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  logic [1:0]  req_op1,
   input  logic        req_setf1,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic [3:0]  nzcv,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   logic        last_grant;
   logic        grant;
   logic        grant_any;
   logic        g_p0;
   logic        setf_p0;
   logic [31:0] a_p0;
   logic [31:0] b_p0;
   logic [1:0]  op_p0;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;

   // Contention goes to the requester that did not win last time (when RR_EN).
   always_comb begin
      grant_any = |req_valid;
      case (req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = RR_EN ? ~last_grant : 1'b0;
         default: grant = 1'b0;
      endcase
      req_ready = 2'b00;
      if (state == IDLE && !reset && grant_any)
         req_ready = grant ? 2'b10 : 2'b01;
   end

   assign busy = (state != IDLE);

   ula32 u_alu (
      .a      (a_p0),
      .b      (b_p0),
      .op     (op_p0),
      .result (alu_result),
      .flags  (alu_flags)
   );

   // Stage p0: operand capture from the granted requester
   always_ff @(posedge clk) begin
      if (state == IDLE && grant_any) begin
         a_p0  <= grant ? req_a1  : req_a0;
         b_p0  <= grant ? req_b1  : req_b0;
         op_p0 <= grant ? req_op1 : req_op0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rsp_valid  <= 2'b00;
         rsp_result <= 32'd0;
         rsp_flags  <= 4'd0;
         nzcv       <= 4'd0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  g_p0       <= grant;
                  setf_p0    <= grant ? req_setf1 : req_setf0;
                  last_grant <= grant;
                  state      <= EXEC;
               end
            end
            // Stage p1: ALU output registered into the response channel
            EXEC: begin
               rsp_result <= alu_result;
               rsp_flags  <= alu_flags;
               if (setf_p0)
                  nzcv <= alu_flags;
               rsp_valid <= g_p0 ? 2'b10 : 2'b01;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready[g_p0]) begin
                  rsp_valid <= 2'b00;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ula_arb2.sv
// Bench for ula_arb2: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a transaction-level model.

module tb_ula_arb2;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, rsp_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]  req_op0, req_op1;
   logic        req_setf0, req_setf1;
   logic [1:0]  req_ready, rsp_valid, fp_req_ready, fp_rsp_valid;
   logic [31:0] rsp_result, fp_rsp_result;
   logic [3:0]  rsp_flags, nzcv, fp_rsp_flags, fp_nzcv;
   logic        busy, fp_busy;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   ula_arb2 #(.RR_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0), .req_setf0(req_setf0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1), .req_setf1(req_setf1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .nzcv(nzcv), .busy(busy)
   );

   ula_arb2 #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(fp_req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0), .req_setf0(req_setf0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1), .req_setf1(req_setf1),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(fp_rsp_result),
      .rsp_flags(fp_rsp_flags), .nzcv(fp_nzcv), .busy(fp_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU from arithmetic meaning: unsigned carry/borrow, signed overflow.
   function automatic void alu_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] op, output logic [31:0] r,
                                     output logic [3:0] f);
      longint sa, sb, sr, ua, ub;
      logic c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      c = 1'b0; v = 1'b0; sr = 0;
      case (op)
         2'd0: begin r = a + b; c = (((ua + ub) >> 32) != 0); sr = sa + sb; end
         2'd1: begin r = a - b; c = (ua >= ub); sr = sa - sb; end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
      if (!op[1]) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      f = {r[31], (r == 32'd0), c, v};
   endfunction

   // Transaction model: one op outstanding; m_age counts edges since acceptance.
   bit          m_busy = 0;
   int          m_age = 0;
   bit          m_g = 0;
   bit          m_last = 1;
   logic [31:0] m_a, m_b, m_res = 0;
   logic [1:0]  m_op, m_r;
   bit          m_setf;
   logic [3:0]  m_flags = 0, m_nzcv = 0;

   function automatic logic [1:0] exp_ready();
      if (reset || m_busy || req_valid == 2'b00) return 2'b00;
      if (req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
      return req_valid;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 0; m_res = 0; m_flags = 0; m_nzcv = 0; m_last = 1;
      end else if (m_busy) begin
         if (m_age == 1) begin
            alu_model(m_a, m_b, m_op, m_res, m_flags);
            if (m_setf) m_nzcv = m_flags;
            m_age = 2;
         end else if (rsp_ready[m_g]) begin
            m_busy = 0;
         end
      end else begin
         m_r = exp_ready();
         if (m_r != 2'b00) begin
            m_g    = m_r[1];
            m_last = m_g;
            m_a    = m_g ? req_a1 : req_a0;
            m_b    = m_g ? req_b1 : req_b0;
            m_op   = m_g ? req_op1 : req_op0;
            m_setf = m_g ? req_setf1 : req_setf0;
            m_busy = 1;
            m_age  = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 32'(req_ready), 32'(exp_ready()));
         check("rsp_valid", 32'(rsp_valid),
               32'((m_busy && m_age >= 2) ? (m_g ? 2'b10 : 2'b01) : 2'b00));
         check("busy", 32'(busy), 32'(m_busy));
         check("nzcv", 32'(nzcv), 32'(m_nzcv));
         check("rsp_result", rsp_result, m_res);
         check("rsp_flags", 32'(rsp_flags), 32'(m_flags));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      while ((busy | fp_busy) !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check("idle_wait", 32'(busy | fp_busy), 32'd0);
   endtask

   task automatic run_op(input bit g, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input bit setf, input logic [31:0] er,
                         input logic [3:0] ef, input logic [3:0] en);
      logic [1:0] oh;
      oh = g ? 2'b10 : 2'b01;
      wait_idle();
      if (g) begin req_a1 = a; req_b1 = b; req_op1 = op; req_setf1 = setf; end
      else   begin req_a0 = a; req_b0 = b; req_op0 = op; req_setf0 = setf; end
      req_valid = oh;
      #1;
      check("op_ready", 32'(req_ready), 32'(oh));
      check("op_fp_ready", 32'(fp_req_ready), 32'(oh));
      tick();
      req_valid = 2'b00;
      check("op_exec_nvalid", 32'(rsp_valid), 32'd0);
      check("op_exec_busy", 32'(busy), 32'd1);
      tick();
      check("op_rsp_valid", 32'(rsp_valid), 32'(oh));
      check("op_result", rsp_result, er);
      check("op_flags", 32'(rsp_flags), 32'(ef));
      check("op_nzcv", 32'(nzcv), 32'(en));
      check("op_fp_valid", 32'(fp_rsp_valid), 32'(oh));
      check("op_fp_result", fp_rsp_result, er);
      check("op_fp_flags", 32'(fp_rsp_flags), 32'(ef));
      tick();
      check("op_done_valid", 32'(rsp_valid), 32'd0);
      check("op_done_busy", 32'(fp_busy | busy), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1);
   end

   initial begin
      int q[$];
      int fp0, fp1;
      reset = 1'b1;
      req_valid = 2'b11; rsp_ready = 2'b00;
      req_a0 = 0; req_b0 = 0; req_op0 = 0; req_setf0 = 0;
      req_a1 = 0; req_b1 = 0; req_op1 = 0; req_setf1 = 0;
      repeat (3) tick();
      chk_en = 1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_nzcv", 32'(nzcv), 32'd0);
      check("rst_result", rsp_result, 32'd0);
      check("rst_flags", 32'(rsp_flags), 32'd0);
      reset = 1'b0;
      req_valid = 2'b00;

      run_op(0, 32'd5, 32'd3, 2'd0, 1, 32'h8, 4'b0000, 4'b0000);
      run_op(1, 32'd3, 32'd3, 2'd1, 1, 32'h0, 4'b0110, 4'b0110);
      run_op(0, 32'hF0F0F0F0, 32'hFFFF0000, 2'd2, 0, 32'hF0F00000, 4'b1000, 4'b0110);
      run_op(0, 32'h7FFFFFFF, 32'hFFFFFFFF, 2'd1, 1, 32'h80000000, 4'b1001, 4'b1001);
      run_op(0, 32'hFFFFFFFF, 32'h1, 2'd0, 1, 32'h0, 4'b0110, 4'b0110);

      // Continuous contention right after reset
      reset = 1'b1; req_valid = 2'b00;
      tick(); tick();
      reset = 1'b0;
      req_valid = 2'b11; rsp_ready = 2'b11;
      fp0 = 0; fp1 = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (req_ready == 2'b01) q.push_back(0);
         else if (req_ready == 2'b10) q.push_back(1);
         if (fp_req_ready == 2'b01) fp0++;
         else if (fp_req_ready == 2'b10) fp1++;
         tick();
      end
      check("rr_grant_count", 32'(q.size()), 32'd4);
      for (int k = 0; k < q.size(); k++)
         check("rr_grant_order", 32'(q[k]), 32'(k % 2));
      check("fp_grants0", 32'(fp0), 32'd4);
      check("fp_grants1", 32'(fp1), 32'd0);

      // Backpressure in RESP, with requester 1 waiting and its rsp_ready bit set
      wait_idle();
      req_a0 = 32'd10; req_b0 = 32'd20; req_op0 = 2'd0; req_setf0 = 0;
      rsp_ready = 2'b10;
      req_valid = 2'b01;
      #1;
      check("bp_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b10;
      req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = 2'd3; req_setf1 = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_result", rsp_result, 32'd30);
         check("bp_flags", 32'(rsp_flags), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 2'b01;
      #1;
      check("bp_still_valid", 32'(rsp_valid), 32'd1);
      tick();
      check("bp_idle_busy", 32'(busy), 32'd0);
      check("bp_idle_valid", 32'(rsp_valid), 32'd0);
      check("bp_next_ready", 32'(req_ready), 32'd2);
      tick();
      check("bp_next_accept", 32'(busy), 32'd1);
      req_valid = 2'b00; rsp_ready = 2'b11;

      // Reset while a setf op is in EXEC
      run_op(0, 32'h80000000, 32'h0, 2'd3, 1, 32'h80000000, 4'b1000, 4'b1000);
      wait_idle();
      req_a0 = 32'hFFFFFFFF; req_b0 = 32'h1; req_op0 = 2'd0; req_setf0 = 1;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      check("rx_in_exec", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rx_valid", 32'(rsp_valid), 32'd0);
         check("rx_busy", 32'(busy), 32'd0);
         check("rx_nzcv", 32'(nzcv), 32'd0);
         check("rx_fp_nzcv", 32'(fp_nzcv), 32'd0);
         tick();
      end
      run_op(1, 32'd7, 32'd2, 2'd1, 1, 32'd5, 4'b0010, 4'b0010);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 299) == 0);
         req_valid = 2'($urandom_range(0, 3));
         rsp_ready = 2'($urandom_range(0, 3));
         req_a0 = pick(); req_b0 = pick();
         req_a1 = pick(); req_b1 = pick();
         req_op0 = 2'($urandom_range(0, 3)); req_op1 = 2'($urandom_range(0, 3));
         req_setf0 = 1'($urandom_range(0, 1)); req_setf1 = 1'($urandom_range(0, 1));
         tick();
      end
      reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
